// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch unit with a 2-entry instruction buffer.
//   Reads instruction memory at PC_COUNT, advances the external PC register
//   through PC_DIN/PC_WRITE, and hands fetched words to the decoder over a
//   valid/ready handshake. Execute-stage redirects flush the buffer and
//   retarget the PC. A redirect that arrives while a read is outstanding lets
//   that read finish and throws its data away (ABORT).
// Ports:
//   CLK, RST_N                   clock, async active-low reset
//   PC_COUNT / PC_DIN / PC_WRITE PC register read value, next value, load enable
//   REDIRECT / REDIRECT_ADDR     execute-stage retarget pulse and target
//   MEM_REQ / MEM_ADDR           instruction memory request (held until MEM_ACK)
//   MEM_ACK / MEM_RDATA          memory completion and read data
//   IR_VALID / IR_READY          decoder handshake for the buffer head
//   IR_DATA / IR_PC              head instruction and its address
//   MISALIGN                     sticky misaligned-redirect flag
// Build option:
//   IFETCH_ALIGN_CHECK_EN        misaligned redirects set MISALIGN and halt fetch;
//                                when undefined the low two target bits are dropped.
module ifetch_unit #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] PC_COUNT,
    output logic [ADDR_W-1:0] PC_DIN,
    output logic              PC_WRITE,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_ADDR,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              IR_VALID,
    input  logic              IR_READY,
    output logic [DATA_W-1:0] IR_DATA,
    output logic [ADDR_W-1:0] IR_PC,
    output logic              MISALIGN
);

    typedef enum logic [1:0] {FETCH, FULL, ABORT, HALT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [ADDR_W-1:0] abort_addr_q, abort_addr_d;
    logic              halt_pend_q, halt_pend_d;

    logic              redir_eff;
    logic              redir_mis;
    logic [ADDR_W-1:0] redir_target;
    logic              mem_req_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic              ack_acc;
    logic              pop;

    // Redirect target and misalignment detection depend on the build option.
`ifdef IFETCH_ALIGN_CHECK_EN
    assign redir_mis    = (REDIRECT_ADDR[1:0] != 2'b00);
    assign redir_target = REDIRECT_ADDR;
`else
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^REDIRECT_ADDR[1:0];
    assign redir_mis        = 1'b0;
    assign redir_target     = {REDIRECT_ADDR[ADDR_W-1:2], 2'b00};
`endif

    // Memory request, PC update and buffer/next-state logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data0_d      = data0_q;
        data1_d      = data1_q;
        pc0_d        = pc0_q;
        pc1_d        = pc1_q;
        abort_addr_d = abort_addr_q;
        halt_pend_d  = halt_pend_q;
        mem_req_c    = 1'b0;
        mem_addr_c   = PC_COUNT;

        case (state_q)
            FETCH:   mem_req_c = (cnt_q < 2'd2);
            ABORT: begin
                mem_req_c  = 1'b1;
                mem_addr_c = abort_addr_q;
            end
            default: mem_req_c = 1'b0;
        endcase
        if (!RST_N) mem_req_c = 1'b0;

        redir_eff = REDIRECT && (state_q != HALT);
        ack_acc   = mem_req_c && MEM_ACK && !redir_eff && (state_q == FETCH);
        pop       = (cnt_q != 2'd0) && IR_READY;

        PC_WRITE = (redir_eff || ack_acc) && RST_N;
        PC_DIN   = redir_eff ? redir_target : mem_addr_c + ADDR_W'(4);

        // Shift-register buffer: entry 0 is the head.
        if (redir_eff) begin
            cnt_d = 2'd0;
        end else begin
            if (pop) begin
                data0_d = data1_q;
                pc0_d   = pc1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            if (ack_acc) begin
                if (cnt_d == 2'd0) begin
                    data0_d = MEM_RDATA;
                    pc0_d   = mem_addr_c;
                end else begin
                    data1_d = MEM_RDATA;
                    pc1_d   = mem_addr_c;
                end
                cnt_d = cnt_d + 2'd1;
            end
        end

        case (state_q)
            FETCH, FULL: begin
                if (redir_eff) begin
                    if (mem_req_c && !MEM_ACK) begin
                        state_d      = ABORT;
                        abort_addr_d = mem_addr_c;
                        halt_pend_d  = redir_mis;
                    end else begin
                        state_d = redir_mis ? HALT : FETCH;
                    end
                end else begin
                    state_d = (cnt_d == 2'd2) ? FULL : FETCH;
                end
            end
            ABORT: begin
                if (redir_eff && redir_mis) halt_pend_d = 1'b1;
                // Outstanding read completes; its data is dropped.
                if (MEM_ACK) state_d = halt_pend_d ? HALT : FETCH;
            end
            default: state_d = HALT;
        endcase
    end

    assign MEM_REQ  = mem_req_c;
    assign MEM_ADDR = mem_addr_c;
    assign IR_VALID = (cnt_q != 2'd0);
    assign IR_DATA  = data0_q;
    assign IR_PC    = pc0_q;

    // State and buffer registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= FETCH;
            cnt_q        <= 2'd0;
            data0_q      <= '0;
            data1_q      <= '0;
            pc0_q        <= '0;
            pc1_q        <= '0;
            abort_addr_q <= '0;
            halt_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            pc0_q        <= pc0_d;
            pc1_q        <= pc1_d;
            abort_addr_q <= abort_addr_d;
            halt_pend_q  <= halt_pend_d;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // Sticky flag for any accepted misaligned redirect.
    always_comb begin
        misalign_d = misalign_q | (redir_eff & redir_mis);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end

    assign MISALIGN = misalign_q;
`else
    assign MISALIGN = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_count;
    logic [31:0] pc_din;
    logic        pc_write;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int          mem_lat = 0;
    int          wait_cnt;
    int          acks;
    logic [31:0] pc_init;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .CLK(clk), .RST_N(rst_n),
        .PC_COUNT(pc_count), .PC_DIN(pc_din), .PC_WRITE(pc_write),
        .REDIRECT(redirect), .REDIRECT_ADDR(redirect_addr),
        .MEM_REQ(mem_req), .MEM_ADDR(mem_addr), .MEM_ACK(mem_ack), .MEM_RDATA(mem_rdata),
        .IR_VALID(ir_valid), .IR_READY(ir_ready), .IR_DATA(ir_data), .IR_PC(ir_pc),
        .MISALIGN(misalign)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // PC register model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pc_count <= pc_init;
        else if (pc_write) pc_count <= pc_din;
    end

    // Memory model: ack after mem_lat wait cycles; tolerates abandoned requests
    assign mem_ack   = mem_req && (wait_cnt >= mem_lat);
    assign mem_rdata = mem_word(mem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
        end else begin
            if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
            else                     wait_cnt <= 0;
            if (mem_req && mem_ack)  acks <= acks + 1;
        end
    end

    // Scoreboard monitor: compares every decoder handshake against the queue
    always @(negedge clk) begin
        if (rst_n && ir_valid && ir_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ir_pop unexpected delivery pc=%h data=%h required=none", ir_pc, ir_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (ir_pc !== e.pc || ir_data !== e.data) begin
                    failures++;
                    $display("FAIL ir_pop actual pc=%h data=%h required pc=%h data=%h",
                             ir_pc, ir_data, e.pc, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.data = mem_word(a);
        exp_q.push_back(e);
    endtask

    // Reset (checking outputs while held), then release just after an edge
    task automatic do_reset(input logic [31:0] init);
        pc_init       = init;
        rst_n         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 32'h0;
        ir_ready      = 1'b0;
        acks          = 0;
        exp_q.delete();
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_pc_write", 64'(pc_write), 64'd0);
        chk("rst_ir_valid", 64'(ir_valid), 64'd0);
        chk("rst_ir_data", 64'(ir_data), 64'd0);
        chk("rst_ir_pc", 64'(ir_pc), 64'd0);
        chk("rst_misalign", 64'(misalign), 64'd0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // T1: zero-wait stream, one per cycle, 1-cycle ack-to-valid
        mem_lat = 0;
        do_reset(32'h0);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        ir_ready = 1'b1;
        repeat (4) step();
        chk("t1_throughput", 64'(exp_q.size()), 64'd0);
        ir_ready = 1'b0;

        // T2: decoder stalled -> two pushes then FULL; one pop -> one fetch at 0x8
        do_reset(32'h0);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        repeat (4) step();
        chk("t2_full_req", 64'(mem_req), 64'd0);
        chk("t2_full_pc", 64'(pc_count), 64'h8);
        chk("t2_full_acks", 64'(acks), 64'd2);
        chk("t2_head_pc", 64'(ir_pc), 64'h0);
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        step();
        chk("t2_refill_pc", 64'(pc_count), 64'hC);
        chk("t2_refill_acks", 64'(acks), 64'd3);
        chk("t2_refill_req", 64'(mem_req), 64'd0);
        ir_ready = 1'b1;
        wait_empty("t2_drain");
        ir_ready = 1'b0;

        // T3: 3-cycle memory, redirect in 2nd wait cycle -> ABORT
        mem_lat = 3;
        do_reset(32'h0);
        push_exp(32'h100);
        ir_ready = 1'b1;
        step();
        redirect      = 1'b1;
        redirect_addr = 32'h100;
        step();
        redirect = 1'b0;
        chk("t3_abort_req", 64'(mem_req), 64'd1);
        chk("t3_abort_addr", 64'(mem_addr), 64'h0);
        chk("t3_abort_pc", 64'(pc_count), 64'h100);
        step();
        chk("t3_abort_ack", 64'(mem_ack), 64'd1);
        chk("t3_abort_nowrite", 64'(pc_write), 64'd0);
        step();
        chk("t3_new_req", 64'(mem_req), 64'd1);
        chk("t3_new_addr", 64'(mem_addr), 64'h100);
        chk("t3_no_push", 64'(ir_valid), 64'd0);
        wait_empty("t3_drain");
        ir_ready = 1'b0;

        // T4: redirect coincident with ack, one buffered entry popped
        mem_lat = 0;
        do_reset(32'h0);
        push_exp(32'h0); push_exp(32'h40);
        step();
        redirect      = 1'b1;
        redirect_addr = 32'h40;
        ir_ready      = 1'b1;
        #1;
        chk("t4_coinc_ack", 64'(mem_ack), 64'd1);
        chk("t4_pc_write", 64'(pc_write), 64'd1);
        chk("t4_pc_din", 64'(pc_din), 64'h40);
        step();
        redirect = 1'b0;
        ir_ready = 1'b0;
        chk("t4_flushed", 64'(ir_valid), 64'd0);
        chk("t4_pc", 64'(pc_count), 64'h40);
        chk("t4_popped", 64'(exp_q.size()), 64'd1);
        chk("t4_new_addr", 64'(mem_addr), 64'h40);
        ir_ready = 1'b1;
        wait_empty("t4_drain");
        ir_ready = 1'b0;

        // T5: PC wrap at top of address space
        do_reset(32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC);
        #1;
        chk("t5_addr", 64'(mem_addr), 64'hFFFF_FFFC);
        chk("t5_pc_write", 64'(pc_write), 64'd1);
        chk("t5_pc_din_wrap", 64'(pc_din), 64'h0);
        step();
        chk("t5_pc_wrapped", 64'(pc_count), 64'h0);
        ir_ready = 1'b1;
        wait_empty("t5_drain");
        ir_ready = 1'b0;

        // T6: misaligned redirect from FULL
        do_reset(32'h0);
        repeat (2) step();
        redirect      = 1'b1;
        redirect_addr = 32'h102;
        #1;
        chk("t6_pc_write", 64'(pc_write), 64'd1);
        step();
        redirect = 1'b0;
        chk("t6_flushed", 64'(ir_valid), 64'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("t6_misalign", 64'(misalign), 64'd1);
        chk("t6_halt_req", 64'(mem_req), 64'd0);
        repeat (3) step();
        chk("t6_halt_req_later", 64'(mem_req), 64'd0);
        chk("t6_halt_valid", 64'(ir_valid), 64'd0);
        redirect      = 1'b1;
        redirect_addr = 32'h200;
        #1;
        chk("t6_halt_ignore", 64'(pc_write), 64'd0);
        step();
        redirect = 1'b0;
        chk("t6_halt_stays", 64'(mem_req), 64'd0);
        chk("t6_misalign_sticky", 64'(misalign), 64'd1);
`else
        chk("t6_misalign_off", 64'(misalign), 64'd0);
        chk("t6_req", 64'(mem_req), 64'd1);
        chk("t6_addr", 64'(mem_addr), 64'h100);
        chk("t6_pc", 64'(pc_count), 64'h100);
        push_exp(32'h100);
        ir_ready = 1'b1;
        wait_empty("t6_drain");
        ir_ready = 1'b0;
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the single-cycle/multicycle core. It reads instruction memory at the address held by the program counter register and advances that register by driving its `PC_DIN`/`PC_WRITE` inputs. Fetched words go into a 2-entry buffer and are handed to the decoder over a valid/ready handshake. Execute-stage redirects (branch/jump) flush the buffer and retarget the PC.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, instruction width
- `CLK`  in  1  clock; everything samples on rising edge
- `RST_N`  in  1  reset, asynchronous, active-low
- `PC_COUNT`  in  ADDR_W  current PC register value (fetch address source)
- `PC_DIN`  out  ADDR_W  next PC value to PC register
- `PC_WRITE`  out  1  PC register load enable
- `REDIRECT`  in  1  one-cycle pulse from execute: retarget fetch
- `REDIRECT_ADDR`  in  ADDR_W  redirect target
- `MEM_REQ`  out  1  instruction memory read request
- `MEM_ADDR`  out  ADDR_W  read address
- `MEM_ACK`  in  1  read complete; `MEM_RDATA` valid this cycle
- `MEM_RDATA`  in  DATA_W  read data
- `IR_VALID`  out  1  buffer head valid
- `IR_READY`  in  1  decoder accepts head
- `IR_DATA`  out  DATA_W  head instruction
- `IR_PC`  out  ADDR_W  address of head instruction
- `MISALIGN`  out  1  sticky misaligned-redirect flag (macro-dependent)

## Operation
- States: FETCH, FULL, ABORT, HALT (HALT only with macro).
- FETCH: `MEM_REQ`=1 and `MEM_ADDR`=`PC_COUNT` whenever buffer count < 2. Memory protocol: request and address held stable until `MEM_ACK`; ACK is allowed in the same cycle as REQ.
- Accepted ACK (`MEM_REQ`&`MEM_ACK`, no redirect, not ABORT): push {`MEM_RDATA`, `MEM_ADDR`} into the buffer. Assert `PC_WRITE`=1 and `PC_DIN`=`MEM_ADDR`+4 combinationally in that cycle, so the PC and buffer update on the same edge. Addition wraps modulo 2^ADDR_W.
- Buffer pop when `IR_VALID`&`IR_READY`. Push and pop may occur in the same cycle.
- FETCH->FULL when the post-edge count = 2. FULL->FETCH on any pop. No request is issued in FULL.
- REDIRECT (any state except HALT) takes priority over ACK:
  - `PC_WRITE`=1, `PC_DIN`=`REDIRECT_ADDR`.
  - Buffer flushed at the edge. A pop handshaking in the same cycle is honoured; the remaining entries are dropped.
  - If `MEM_REQ` is high without `MEM_ACK`, go to ABORT. A redirect coinciding with ACK discards the data and stays in FETCH.
- ABORT: `MEM_REQ` held high with `MEM_ADDR` frozen at the registered aborted address until ACK. The returning data is discarded, `PC_WRITE`=0, then the unit returns to FETCH. A further REDIRECT in ABORT updates the PC and remains in ABORT.
- `IR_VALID`, `IR_DATA`, `IR_PC` come from buffer registers (head), not from `MEM_RDATA`.

## Timing
- Reset (async assert): state FETCH, buffer empty. `IR_VALID`=0, `IR_DATA`=0, `IR_PC`=0, `MISALIGN`=0.
  - `MEM_REQ`=0 and `PC_WRITE`=0 while `RST_N` is low.
  - `MEM_REQ` may rise in the first cycle after `RST_N` deasserts.
- ACK-to-`IR_VALID` latency: 1 cycle (edge at the ACK cycle).
- Throughput: one instruction per cycle with zero-wait memory and `IR_READY` held high.
- Redirect-to-new-request: the next cycle, with `MEM_ADDR`=`REDIRECT_ADDR` (via `PC_COUNT`), unless in ABORT.
- Reset mid-request: the request drops immediately and the buffer empties; the memory must tolerate an abandoned request.
- `PC_WRITE` is combinational from state, `MEM_ACK` and `REDIRECT`. It is never asserted while `RST_N` is low.

## Configuration
- Macro `IFETCH_ALIGN_CHECK_EN`.
- Defined: a REDIRECT with `REDIRECT_ADDR[1:0]`≠0 does the following:
  - Sets `MISALIGN`=1 (sticky until reset).
  - Flushes the buffer and enters HALT. In HALT, `MEM_REQ`=0, `PC_WRITE`=0 and REDIRECT is ignored.
  - If a request is outstanding, the unit first completes it as in ABORT, then enters HALT.
- Undefined: `PC_DIN` uses `{REDIRECT_ADDR[ADDR_W-1:2],2'b00}`, `MISALIGN` is tied to 0, and HALT is unreachable.

## Test plan
- Reset release, PC=0x0, zero-wait memory, `IR_READY`=1 -> fetches 0x0, 0x4, 0x8 on consecutive cycles. `IR_PC` follows 0x0, 0x4, 0x8, one cycle after each ACK.
- `IR_READY`=0, zero-wait memory -> exactly 2 pushes (0x0, 0x4), then `MEM_REQ`=0 and PC=0x8. Raising `IR_READY` for 1 cycle -> one pop and one new fetch at 0x8.
- 3-cycle memory latency, REDIRECT to 0x100 in the 2nd wait cycle -> ABORT, the ACK data for the old address is discarded with no push, then `MEM_ADDR`=0x100 next cycle and `IR_PC`=0x100 is the first delivered.
- REDIRECT to 0x40 on the same cycle as ACK, with 1 buffered entry and a pop -> the popped entry is delivered, the ACK data is dropped, the buffer is empty, and PC=0x40.
- PC at 0xFFFFFFFC, ACK -> `PC_DIN`=0x00000000 (wrap).
- With `IFETCH_ALIGN_CHECK_EN`, REDIRECT to 0x102 -> `MISALIGN`=1, `MEM_REQ` stays 0 thereafter, and `IR_VALID`=0. Without the macro -> fetch at 0x100.
